// File: rtl/lsu_multicycle.sv
// lsu_multicycle: load/store unit with valid/ready request/response, req/ack memory
// handshake, lane steering with byte enables, misalignment detection and ack timeout.
module lsu_multicycle #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

    state_t          state, state_nx;
    logic [OW-1:0]   off, off_q;
    logic [1:0]      size_q;
    logic            sgn_q;
    logic [CW-1:0]   cnt;
    logic            accept, bad, ack, tmo, lsign;
    logic [DATA_W-1:0] wmask, lane, lmask, ldata;

    assign req_ready = state == IDLE;
    assign accept    = req_valid && req_ready;
    assign off       = req_addr[OW-1:0];
    assign bad       = |(off & OW'((1 << req_size) - 1)) || (DATA_W == 32 && req_size == 2'b11);
    assign ack       = state == MEM && mem_ack;
    // Firing one count early makes mem_req high for exactly TIMEOUT cycles.
    assign tmo       = TIMEOUT != 0 && state == MEM && cnt == CW'(TIMEOUT - 1);
    assign wmask     = ~({DATA_W{1'b1}} << (8 << req_size));

    always_comb begin
        lane  = mem_rdata >> {off_q, 3'b000};
        lmask = ~({DATA_W{1'b1}} << (8 << size_q));
        lsign = sgn_q & |(lane & lmask & ~(lmask >> 1));
        ldata = (lane & lmask) | ({DATA_W{lsign}} & ~lmask);
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE && accept) state_nx = bad ? RESP : MEM;
        else if (state == MEM && (ack || tmo)) state_nx = RESP;
        else if (state == RESP && resp_ready) state_nx = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            off_q      <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 2'b00;
        end else begin
            if (accept) begin
                off_q      <= off;
                size_q     <= req_size;
                sgn_q      <= req_signed;
                cnt        <= '0;
                resp_valid <= bad;
                resp_err   <= bad ? 2'b01 : 2'b00;
                resp_rdata <= '0;
                mem_req    <= !bad;
                if (!bad) begin
                    mem_we    <= req_write;
                    mem_addr  <= {req_addr[ADDR_W-1:OW], OW'(0)};
                    mem_be    <= ~({NB{1'b1}} << (1 << req_size)) << off;
                    mem_wdata <= (req_wdata & wmask) << {off, 3'b000};
                end
            end
            if (state == MEM) begin
                cnt <= cnt + 1'b1;
                if (ack || tmo) begin
                    mem_req    <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= ack ? 2'b00 : 2'b10;
                    resp_rdata <= (ack && !mem_we) ? ldata : '0;
                end
            end
            if (state == RESP && resp_ready) resp_valid <= 1'b0;
        end
    end
endmodule
